// File: rtl/fm_radio_pkg.sv
// -----------------------------------------------------------------------------
// fm_radio_pkg
//   Shared constants, fixed-point helpers and the FM discriminator state type.
//   All sample arithmetic is signed two's complement Q10 (1.0 = 1024).
//   No ports (package).
// -----------------------------------------------------------------------------
package fm_radio_pkg;

   localparam int DATA_WIDTH       = 32;
   localparam int PROD_WIDTH       = 2 * DATA_WIDTH;
   localparam int BITS             = 10;
   localparam int QUANT_VAL        = 1 << BITS;
   localparam int QUARTER_PI       = 804;
   localparam int THREE_QUARTER_PI = 2412;
   localparam int DEMOD_GAIN       = 758;

   typedef enum logic [2:0] {
      S_READ      = 3'd0,
      S_MULT      = 3'd1,
      S_DIV_START = 3'd2,
      S_DIV_WAIT  = 3'd3,
      S_ANGLE     = 3'd4,
      S_GAIN      = 3'd5,
      S_WRITE     = 3'd6
   } demod_state_t;

   // Arithmetic shift right by BITS (floor), then truncate to the sample width.
   function automatic logic signed [DATA_WIDTH-1:0] dequant(input logic signed [PROD_WIDTH-1:0] p);
      logic signed [PROD_WIDTH-1:0] s;
      s = p >>> BITS;
      return s[DATA_WIDTH-1:0];
   endfunction

   // Full-precision signed product of two samples.
   function automatic logic signed [PROD_WIDTH-1:0] smul(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
      logic signed [PROD_WIDTH-1:0] ea;
      logic signed [PROD_WIDTH-1:0] eb;
      ea = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
      eb = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
      return ea * eb;
   endfunction

endpackage

// File: rtl/fm_demod_divider.sv
// -----------------------------------------------------------------------------
// fm_demod_divider
//   Unsigned restoring divider, WIDTH iterations. The first iteration is done
//   in the start cycle, so done_o is high exactly WIDTH cycles after start_i
//   and quotient_o is valid while done_o is high (and held afterwards).
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high
//   start_i      in   load operands and begin a division
//   dividend_i   in   WIDTH unsigned dividend
//   divisor_i    in   WIDTH unsigned divisor (caller guarantees non-zero)
//   quotient_o   out  WIDTH unsigned quotient
//   done_o       out  one-cycle pulse when quotient_o is final
// -----------------------------------------------------------------------------
module fm_demod_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic             done_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   dvs_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [2*WIDTH-1:0] step_load;
   logic [2*WIDTH-1:0] step_run;

   // One restoring step: shift the next dividend bit into the partial
   // remainder, subtract the divisor if it fits, shift the result bit in.
   // The dividend register doubles as the quotient register.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] quo,
                                                   input logic [WIDTH-1:0] dvs);
      logic [WIDTH:0] trial;
      logic           bit_n;
      trial = {rem, quo[WIDTH-1]};
      bit_n = 1'b0;
      if (trial >= {1'b0, dvs}) begin
         trial = trial - {1'b0, dvs};
         bit_n = 1'b1;
      end
      return {trial[WIDTH-1:0], quo[WIDTH-2:0], bit_n};
   endfunction

   always_comb begin
      step_load = div_step('0, dividend_i, divisor_i);
      step_run  = div_step(rem_q, quo_q, dvs_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            {rem_q, quo_q} <= step_load;
            dvs_q          <= divisor_i;
            cnt_q          <= CW'(1);
            busy_q         <= 1'b1;
         end else if (busy_q) begin
            {rem_q, quo_q} <= step_run;
            cnt_q          <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   // The remainder is only needed internally.
   assign quotient_o = quo_q;
   assign done_o     = done_q;

endmodule

// File: rtl/fm_demod.sv
// -----------------------------------------------------------------------------
// fm_demod
//   FM discriminator. Pops one I/Q pair, forms s = x[n]*conj(x[n-1]) and
//   writes y = GAIN * qarctan(im(s), re(s)) in Q10 to the output FIFO.
//   One sample is in flight at a time; period is DATA_WIDTH+6 cycles.
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high
//   i_in         in   I sample at head of I FIFO
//   i_empty      in   I FIFO empty
//   i_rd_en      out  pop I FIFO
//   q_in         in   Q sample at head of Q FIFO
//   q_empty      in   Q FIFO empty
//   q_rd_en      out  pop Q FIFO
//   y_out        out  demodulated sample (registered, held between writes)
//   y_wr_en      out  push y_out to output FIFO
//   y_full       in   output FIFO full
//   dbg_state_o  out  current FSM state
// Handshake: a pair is taken only in S_READ when both FIFOs are non-empty;
//   the head values are latched on that edge and a single pop pulse is issued
//   to both FIFOs together in the following cycle. A result is pushed only in
//   S_WRITE when y_full is low; y_out and y_wr_en change on the same edge.
// -----------------------------------------------------------------------------
module fm_demod
   import fm_radio_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] i_in,
   input  logic                  i_empty,
   output logic                  i_rd_en,
   input  logic [DATA_WIDTH-1:0] q_in,
   input  logic                  q_empty,
   output logic                  q_rd_en,
   output logic [DATA_WIDTH-1:0] y_out,
   output logic                  y_wr_en,
   input  logic                  y_full,
   output demod_state_t          dbg_state_o
);

   localparam int MSB = DATA_WIDTH - 1;
   localparam logic signed [DATA_WIDTH-1:0] ONE     = 1;
   localparam logic signed [DATA_WIDTH-1:0] K_QUANT = QUANT_VAL;
   localparam logic signed [DATA_WIDTH-1:0] K_QPI   = QUARTER_PI;
   localparam logic signed [DATA_WIDTH-1:0] K_TQPI  = THREE_QUARTER_PI;
   localparam logic signed [DATA_WIDTH-1:0] K_GAIN  = DEMOD_GAIN;

   demod_state_t                 state_q;
   logic signed [DATA_WIDTH-1:0] prev_i_q, prev_q_q;
   logic signed [DATA_WIDTH-1:0] cur_i_q, cur_q_q;
   logic signed [DATA_WIDTH-1:0] re_q, im_q;
   logic signed [DATA_WIDTH-1:0] base_q;
   logic                         num_neg_q;
   logic signed [DATA_WIDTH-1:0] ang_q;
   logic signed [DATA_WIDTH-1:0] y_c_q;
   logic [DATA_WIDTH-1:0]        y_out_q;
   logic                         rd_en_q;
   logic                         wr_en_q;

   logic signed [DATA_WIDTH-1:0] re_d, im_d;
   logic signed [DATA_WIDTH-1:0] im_abs, a_val;
   logic signed [DATA_WIDTH-1:0] diff_d, num_d, num_abs, den_d, base_d;
   logic signed [DATA_WIDTH-1:0] quo_s, r_d, ang_d, y_c_d;

   logic                  div_start;
   logic [DATA_WIDTH-1:0] div_quo;
   logic                  div_done;

   always_comb begin
      // Conjugate product, each partial product dequantised on its own.
      re_d = dequant(smul(prev_i_q, cur_i_q)) + dequant(smul(prev_q_q, cur_q_q));
      im_d = dequant(smul(prev_i_q, cur_q_q)) - dequant(smul(prev_q_q, cur_i_q));

      // qarctan set-up; the +1 keeps the denominator non-zero.
      im_abs = im_q[MSB] ? -im_q : im_q;
      a_val  = im_abs + ONE;
      diff_d = re_q - a_val;
      den_d  = re_q + a_val;
      base_d = K_QPI;
      if (re_q[MSB]) begin
         diff_d = re_q + a_val;
         den_d  = a_val - re_q;
         base_d = K_TQPI;
      end
      num_d   = diff_d * K_QUANT;
      num_abs = num_d[MSB] ? -num_d : num_d;

      // Restore the sign of the quotient (truncation toward zero).
      quo_s = div_quo;
      r_d   = num_neg_q ? -quo_s : quo_s;
      ang_d = base_q - dequant(smul(K_QPI, r_d));
      if (im_q[MSB]) begin
         ang_d = -ang_d;
      end

      y_c_d = dequant(smul(K_GAIN, ang_q));
   end

   assign div_start = (state_q == S_DIV_START);

   fm_demod_divider #(
      .WIDTH(DATA_WIDTH)
   ) u_divider (
      .clock      (clock),
      .reset      (reset),
      .start_i    (div_start),
      .dividend_i (num_abs),
      .divisor_i  (den_d),
      .quotient_o (div_quo),
      .done_o     (div_done)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_READ;
         prev_i_q  <= '0;
         prev_q_q  <= '0;
         cur_i_q   <= '0;
         cur_q_q   <= '0;
         re_q      <= '0;
         im_q      <= '0;
         base_q    <= '0;
         num_neg_q <= 1'b0;
         ang_q     <= '0;
         y_c_q     <= '0;
         y_out_q   <= '0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         case (state_q)
            S_READ: begin
               if (!i_empty && !q_empty) begin
                  cur_i_q <= i_in;
                  cur_q_q <= q_in;
                  rd_en_q <= 1'b1;
                  state_q <= S_MULT;
               end
            end
            S_MULT: begin
               re_q     <= re_d;
               im_q     <= im_d;
               prev_i_q <= cur_i_q;
               prev_q_q <= cur_q_q;
               state_q  <= S_DIV_START;
            end
            S_DIV_START: begin
               base_q    <= base_d;
               num_neg_q <= num_d[MSB];
               state_q   <= S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
               if (div_done) begin
                  state_q <= S_ANGLE;
               end
            end
            S_ANGLE: begin
               ang_q   <= ang_d;
               state_q <= S_GAIN;
            end
            S_GAIN: begin
               y_c_q   <= y_c_d;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               if (!y_full) begin
                  y_out_q <= y_c_q;
                  wr_en_q <= 1'b1;
                  state_q <= S_READ;
               end
            end
            default: state_q <= S_READ;
         endcase
      end
   end

   // One register drives both pops so they can never split.
   assign i_rd_en     = rd_en_q;
   assign q_rd_en     = rd_en_q;
   assign y_out       = y_out_q;
   assign y_wr_en     = wr_en_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fm_demod.sv
module tb_fm_demod;
   import fm_radio_pkg::*;

   localparam int DW  = 32;
   localparam int LAT = 37;

   // ---------------- clock / reset ----------------
   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic [DW-1:0] i_in    = '0;
   logic          i_empty = 1'b1;
   logic          i_rd_en;
   logic [DW-1:0] q_in    = '0;
   logic          q_empty = 1'b1;
   logic          q_rd_en;
   logic [DW-1:0] y_out;
   logic          y_wr_en;
   logic          y_full  = 1'b0;
   demod_state_t  dbg_state;

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   fm_demod dut (
      .clock       (clock),
      .reset       (reset),
      .i_in        (i_in),
      .i_empty     (i_empty),
      .i_rd_en     (i_rd_en),
      .q_in        (q_in),
      .q_empty     (q_empty),
      .q_rd_en     (q_rd_en),
      .y_out       (y_out),
      .y_wr_en     (y_wr_en),
      .y_full      (y_full),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;
   logic [1:0]    last_pop_pair = 2'b00;
   int            rd_count = 0;
   int            wr_count = 0;
   int            last_rd_cyc = 0;
   int            last_wr_cyc = 0;

   always @(negedge clock) begin
      if (i_rd_en || q_rd_en) begin
         checks++;
         if (i_rd_en !== q_rd_en) begin
            errors++;
            $display("FAIL pop_pair: i_rd_en=%0b q_rd_en=%0b, required equal", i_rd_en, q_rd_en);
         end
         last_pop_pair = {i_rd_en, q_rd_en};
         rd_count++;
         last_rd_cyc = cyc;
      end
      if (y_wr_en) begin
         wr_count++;
         last_wr_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: y_out=%0d written with nothing expected", $signed(y_out));
         end else begin
            mon_exp = exp_q.pop_front();
            if (y_out !== mon_exp) begin
               errors++;
               $display("FAIL y_value: got %0d, expected %0d", $signed(y_out), $signed(mon_exp));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      i_empty = 1'b1;
      q_empty = 1'b1;
      y_full  = 1'b0;
      tick(3);
      check("reset_y_out", y_out, '0);
      check("reset_y_wr_en", DW'(y_wr_en), '0);
      check("reset_rd_en", DW'({i_rd_en, q_rd_en}), '0);
      reset = 1'b0;
      tick(1);
   endtask

   // Present one pair, wait for the pop, then mark both FIFOs empty.
   task automatic send(input string name, input int i, input int q);
      int rc0;
      rc0     = rd_count;
      i_in    = i;
      q_in    = q;
      i_empty = 1'b0;
      q_empty = 1'b0;
      for (int k = 0; k < 200; k++) begin
         tick(1);
         if (rd_count != rc0) break;
      end
      i_empty = 1'b1;
      q_empty = 1'b1;
      checks++;
      if (rd_count == rc0) begin
         errors++;
         $display("FAIL %s_pop_timeout: no pop in 200 cycles, required one", name);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0) break;
         tick(1);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain_timeout: %0d writes outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      int i;
      int q;
      int y;
   } vec_t;

   vec_t vecs[8];
   int   wc0;
   int   rc0;

   initial begin
      // Chained vectors: each result depends on the previous pair.
      vecs[0] = '{1024,     0,  1190};  // prev = 0
      vecs[1] = '{1024,     0,     1};  // r = 1022, ang = 2
      vecs[2] = '{   0,  1024,  1190};  // +90 deg
      vecs[3] = '{   0, -1024,  2379};  // 180 deg, re < 0 branch, ang = 3215
      vecs[4] = '{-1024,    0, -1191};  // im < 0, floor shift
      vecs[5] = '{   0,  1024, -1191};  // -90 deg again
      vecs[6] = '{ 512,   512,  -596};  // quotient 0, ang = -804
      vecs[7] = '{ 512,   512,     2};  // r = 1020, ang = 4

      do_reset();

      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(vecs[k].y);
         send("vec", vecs[k].i, vecs[k].q);
         wait_drain("vec");
         check("vec_latency", DW'(last_wr_cyc - last_rd_cyc), DW'(LAT));
      end

      // Reset clears prev; then a negative-im result.
      do_reset();
      exp_q.push_back(1190);
      send("t3a", 1024, 0);
      wait_drain("t3a");
      exp_q.push_back(-1191);
      send("t3b", 0, -1024);
      wait_drain("t3b");

      // Only the I FIFO has data: nothing may be popped.
      i_in    = 1024;
      q_in    = 0;
      i_empty = 1'b0;
      q_empty = 1'b1;
      rc0     = rd_count;
      tick(50);
      check("t4_no_pop", DW'(rd_count - rc0), '0);
      exp_q.push_back(1190);
      send("t4", 1024, 0);
      check("t4_pair", DW'(last_pop_pair), DW'(2'b11));
      wait_drain("t4");

      // Output FIFO full: stall in S_WRITE with the next pair waiting.
      y_full = 1'b1;
      exp_q.push_back(1);
      send("t5a", 1024, 0);
      i_empty = 1'b0;
      q_empty = 1'b0;
      wc0 = wr_count;
      rc0 = rd_count;
      tick(100);
      check("t5_no_write", DW'(wr_count - wc0), '0);
      check("t5_no_pop", DW'(rd_count - rc0), '0);
      check("t5_state", DW'(dbg_state), DW'(S_WRITE));
      exp_q.push_back(1);
      y_full = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (rd_count != rc0) break;
         tick(1);
      end
      i_empty = 1'b1;
      q_empty = 1'b1;
      check("t5_second_pop", DW'(rd_count - rc0), DW'(1));
      check("t5_one_write", DW'(wr_count - wc0), DW'(1));
      wait_drain("t5");
      check("t5_latency", DW'(last_wr_cyc - last_rd_cyc), DW'(LAT));

      // Reset while the divider is busy: no write, prev cleared.
      send("t6a", 1024, 0);
      tick(10);
      check("t6_state", DW'(dbg_state), DW'(S_DIV_WAIT));
      #1 reset = 1'b1;
      #1;
      check("t6_y_out", y_out, '0);
      check("t6_wr_en", DW'(y_wr_en), '0);
      check("t6_state_reset", DW'(dbg_state), DW'(S_READ));
      tick(2);
      reset = 1'b0;
      wc0 = wr_count;
      tick(60);
      check("t6_no_write", DW'(wr_count - wc0), '0);
      exp_q.push_back(1190);
      send("t6b", 1024, 0);
      wait_drain("t6b");

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
